// File: rtl/sin_pkg.sv
// Shared types for the sin unit request driver and its request buffer.
package sin_pkg;
  typedef logic [31:0] float32_t;
  typedef logic [3:0]  prec_t;

  typedef struct packed {
    float32_t theta;
    prec_t    prec;
  } sin_req_t;

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} drv_state_e;

  localparam float32_t SIN_QNAN = 32'h7fc00000;
endpackage

// File: rtl/sin_req_fifo.sv
// Request buffer for the sin driver: FIFO of sin_req_t, power-of-2 depth,
// push ignored when full, pop ignored when empty.
module sin_req_fifo import sin_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  sin_req_t din,
  input  logic     pop,
  output sin_req_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  sin_req_t      mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = cnt == FULL_CNT;
  assign empty   = cnt == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/sin_req_driver.sv
// Start/done initiator for the sin unit: buffers requests, runs one op at a time,
// returns results in order. Optional WAIT abort via SIN_DRV_TIMEOUT_EN.
module sin_req_driver import sin_pkg::*; #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_theta,
  input  logic [3:0]  req_prec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_timeout,
  output logic        sin_start,
  output logic [31:0] sin_theta,
  output logic [3:0]  sin_prec,
  input  logic [31:0] sin_result,
  input  logic        sin_done,
  output logic        busy
);
  drv_state_e state, state_nxt;
  sin_req_t   req_in, head;
  logic       full, empty, pop, first_wait, done_ok, abort;

  assign req_in    = '{theta: req_theta, prec: req_prec};
  assign req_ready = !full;

  sin_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .din   (req_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // done is still high from the previous op during the first WAIT cycle
  assign done_ok = (state == WAIT) && sin_done && !first_wait;

`ifdef SIN_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wcnt <= '0;
    else if (state == START)  wcnt <= '0;
    else if (state == WAIT)   wcnt <= wcnt + 1'b1;
  end

  assign abort = (state == WAIT) && !done_ok && (wcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES == 0;
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (done_ok || abort) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sin_start = state == START;
    pop       = (state == IDLE) && !empty;
    busy      = (state != IDLE) || !empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sin_theta   <= '0;
      sin_prec    <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_timeout <= 1'b0;
      first_wait  <= 1'b0;
    end else begin
      first_wait <= state == START;
      if (pop) begin
        sin_theta <= head.theta;
        sin_prec  <= head.prec;
      end
      if (done_ok || abort) begin
        out_valid   <= 1'b1;
        out_result  <= abort ? SIN_QNAN : sin_result;
        out_timeout <= abort;
      end else if (state == HOLD && out_ready) begin
        out_valid   <= 1'b0;
        out_timeout <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sin_req_driver.sv
// Scoreboard bench for sin_req_driver with a behavioural sin unit stand-in.
// Timeout scenario is included when SIN_DRV_TIMEOUT_EN is defined.
module tb_sin_req_driver;
  import sin_pkg::*;

  localparam int TO = 40;

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_theta = '0;
  logic [3:0]  req_prec = '0;
  logic        out_valid, out_ready = 1'b0, out_timeout;
  logic [31:0] out_result;
  logic        sin_start;
  logic [31:0] sin_theta;
  logic [3:0]  sin_prec;
  logic [31:0] sin_result = '0;
  logic        sin_done = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  sin_req_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_theta(req_theta), .req_prec(req_prec),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_timeout(out_timeout),
    .sin_start(sin_start), .sin_theta(sin_theta), .sin_prec(sin_prec),
    .sin_result(sin_result), .sin_done(sin_done), .busy(busy)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // known sin() values for the reference angles; other angles use an arbitrary mapping
  function automatic logic [27:0] sin_ref(input logic [31:0] th);
    case (th)
      32'h00000000: return 28'h0000000;
      32'h3f800000: return 28'h3f576aa;
      32'h3f99999a: return 28'h3f6e9a1;
      32'hbfa8f5c3: return 28'hbf77fdb;
      default:      return th[31:4] ^ 28'h5a5a5a5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // sin unit stand-in: done stays high until the cycle after a start, then random latency
  logic        hang = 1'b0, pend = 1'b0;
  int          lat = 0;
  logic [31:0] op_theta = '0;
  logic [3:0]  op_prec = '0;
  always @(posedge clk) begin
    if (sin_start) begin
      pend     <= 1'b1;
      lat      <= $urandom_range(1, 6);
      op_theta <= sin_theta;
      op_prec  <= sin_prec;
    end else if (pend) begin
      pend     <= 1'b0;
      sin_done <= 1'b0;
    end else if (!sin_done && !hang) begin
      if (lat <= 1) begin
        sin_done   <= 1'b1;
        sin_result <= {sin_ref(op_theta), op_prec};
      end else lat <= lat - 1;
    end
  end

  typedef struct { logic [27:0] res; logic to; } exp_t;
  exp_t        exp_q[$];
  sin_req_t    req_q[$];
  int          starts = 0, start_cyc = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res = '0;
  exp_t        e;
  sin_req_t    r;

  // monitor: record accepted requests, check start operands and returned results
  always @(negedge clk) begin
    if (reset) prev_hold <= 1'b0;
    else begin
      if (req_valid && req_ready) begin
        req_q.push_back('{theta: req_theta, prec: req_prec});
        exp_q.push_back('{res: hang ? SIN_QNAN[31:4] : sin_ref(req_theta), to: hang});
      end
      if (sin_start) begin
        starts    <= starts + 1;
        start_cyc <= cyc;
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL start_unexpected: got start with theta %h, expected no start", sin_theta);
        end else begin
          r = req_q.pop_front();
          chk("start_operand", {sin_theta, sin_prec}, {r.theta, r.prec});
        end
      end
      if (prev_hold) chk("out_hold", {out_valid, out_result}, {1'b1, prev_res});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got result %h, expected no output", out_result);
        end else begin
          e = exp_q.pop_front();
          chk("out_result", out_result[31:4], e.res);
          chk("out_timeout", out_timeout, e.to);
        end
      end
      prev_hold <= out_valid && !out_ready;
      prev_res  <= out_result;
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    exp_q.delete(); req_q.delete();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_timeout", out_timeout, 0);
    chk("rst_sin_start", sin_start, 0);
    chk("rst_sin_operand", {sin_theta, sin_prec}, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // caller sits just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [31:0] th, input logic [3:0] pr);
    bit acc = 0;
    int n = 0;
    req_valid = 1'b1; req_theta = th; req_prec = pr;
    while (!acc && n < 500) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_accept: got no accept in 500 cycles, expected accept");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin @(posedge clk); #1; n++; end
    chk("drain_done", {exp_q.size() == 0, busy}, {1'b1, 1'b0});
  endtask

  int  s0, vcyc, n;
  bit  rdone;
  logic [31:0] th;

  initial begin
    do_reset();

    // single request held under back-pressure
    out_ready = 1'b0; s0 = starts;
    send(32'h3f800000, 4'd9);
    repeat (20) @(posedge clk); #1;
    chk("single_valid", out_valid, 1);
    chk("single_theta", sin_theta, 32'h3f800000);
    chk("single_starts", starts - s0, 1);
    out_ready = 1'b1;
    drain();

    // back-to-back burst
    s0 = starts;
    send(32'h00000000, 4'ha); send(32'h3f800000, 4'd9);
    send(32'h3f99999a, 4'd7); send(32'hbfa8f5c3, 4'd8);
    drain();
    chk("burst_starts", starts - s0, 4);

    // 6 offered with consumer stalled: 1 in HOLD, 4 buffered, 6th refused
    out_ready = 1'b0; s0 = starts;
    for (int i = 0; i < 5; i++) send($urandom, 4'($urandom_range(0, 15)));
    req_valid = 1'b1; req_theta = 32'h12345678; req_prec = 4'd3;
    repeat (20) @(posedge clk); #1;
    chk("bp_req_ready", req_ready, 0);
    chk("bp_starts", starts - s0, 1);
    chk("bp_busy_valid", {busy, out_valid}, 2'b11);
    chk("bp_buffered", exp_q.size(), 5);
    req_valid = 1'b0; out_ready = 1'b1;
    drain();

    // randomized traffic with random consumer stalls
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          case ($urandom_range(0, 4))
            0: th = 32'h3f800000;
            1: th = 32'hbfa8f5c3;
            default: th = $urandom;
          endcase
          send(th, 4'($urandom_range(0, 15)));
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin @(posedge clk); #1; out_ready = ($urandom_range(0, 3) != 0); end
      end
    join
    out_ready = 1'b1;
    drain();

    // reset while waiting on the sin unit with two buffered
    hang = 1'b1; s0 = starts;
    send(32'h3f800000, 4'd9); send(32'h3f99999a, 4'd7); send(32'hbfa8f5c3, 4'd8);
    repeat (6) @(posedge clk); #1;
    chk("wait_starts", starts - s0, 1);
    chk("wait_busy", busy, 1);
    do_reset();
    hang = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("post_rst_idle", {out_valid, busy, sin_start}, 3'b000);
    send(32'h3f99999a, 4'd7);
    drain();

`ifdef SIN_DRV_TIMEOUT_EN
    // stalled sin unit: abort after TO wait cycles, then recover
    hang = 1'b1; out_ready = 1'b0;
    send(32'h3f800000, 4'd9);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 4 * TO);
    vcyc = cyc;
    chk("to_latency", vcyc - start_cyc, TO + 1);
    chk("to_result", out_result, 32'h7fc00000);
    chk("to_flag", out_timeout, 1);
    hang = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    send(32'hbfa8f5c3, 4'd8);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "bench time limit");
  end
endmodule
